// File: rtl/abl_seq.sv
// Addressing-mode sequencer for the low address byte path: steps the per-mode
// cycle sequence and drives op/ci/cond/load/increment controls to abl/abh.
module abl_seq #(
   parameter int unsigned VEC_CNT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] mode,
   input  logic       taken,
   input  logic       rdy,
   input  logic       co,
   input  logic       db7,
   output logic [4:0] op,
   output logic       ci,
   output logic       cond,
   output logic       ld_ahl,
   output logic       ld_pc,
   output logic       inc_pc,
   output logic       dec_h,
   output logic       busy,
   output logic       done
);

   localparam int unsigned   VW    = (VEC_CNT > 1) ? $clog2(VEC_CNT) : 1;
   localparam logic [VW-1:0] VLAST = VW'(VEC_CNT - 1);

   typedef enum logic [2:0] {
      M_ZPX,
      M_ABS,
      M_ABSX,
      M_BRA,
      M_VEC
   } mode_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_OPR1,
      S_OPR2,
      S_AHLD,
      S_ZIDX,
      S_IDX,
      S_FIX,
      S_BOFS,
      S_BTGT,
      S_BFIX,
      S_RESTORE,
      S_VEC
   } state_t;

   typedef struct packed {
      logic [4:0] op;
      logic       ci;
      logic       cond;
      logic       ld_ahl;
      logic       ld_pc;
      logic       inc_pc;
      logic       dec_h;
      logic       busy;
      logic       done_u;
   } ctl_t;

   state_t        state;
   state_t        nxt;
   mode_t         mode_r;
   mode_t         nmode;
   logic [VW-1:0] vidx;
   logic [VW-1:0] nvidx;
   ctl_t          ctl;

   // Control word for a state; done_u covers only the unconditional done states.
   function automatic ctl_t decode(input state_t s, input logic [VW-1:0] vi, input logic dh);
      ctl_t c;
      c      = '0;
      c.op   = 5'b00011;
      c.busy = (s != S_IDLE);
      case (s)
         S_OPR1, S_BOFS: begin
            c.ci     = 1'b1;
            c.ld_pc  = 1'b1;
            c.inc_pc = 1'b1;
         end
         S_OPR2: begin
            c.ci     = 1'b1;
            c.ld_pc  = 1'b1;
            c.inc_pc = 1'b1;
            c.ld_ahl = 1'b1;
         end
         S_AHLD: begin
            c.op     = 5'b01010;
            c.done_u = 1'b1;
         end
         S_ZIDX: begin
            c.op     = 5'b01101;
            c.cond   = 1'b1;
            c.done_u = 1'b1;
         end
         S_IDX:  c.op = 5'b01001;
         S_FIX: begin
            c.op     = 5'b10011;
            c.done_u = 1'b1;
         end
         S_BTGT: begin
            c.op    = 5'b01111;
            c.cond  = 1'b1;
            c.ld_pc = 1'b1;
         end
         S_BFIX: begin
            c.op     = 5'b10011;
            c.dec_h  = dh;
            c.done_u = 1'b1;
         end
         S_RESTORE: c.op = 5'b00110;
         S_VEC: begin
            c.op     = 5'b00000;
            c.ci     = (vi != '0);
            c.ld_ahl = (vi != VLAST);
            c.done_u = (vi == VLAST);
         end
         default: ;
      endcase
      return c;
   endfunction

   always_comb begin
      nxt   = state;
      nmode = mode_r;
      nvidx = vidx;
      if (rdy) begin
         case (state)
            S_IDLE: begin
               if (start && (mode <= 3'd4)) begin
                  nmode = mode_t'(mode);
                  nvidx = '0;
                  nxt   = (mode_t'(mode) == M_VEC) ? S_VEC : S_OPR1;
               end
            end
            S_OPR1: begin
               case (mode_r)
                  M_ZPX:   nxt = S_ZIDX;
                  M_BRA:   nxt = S_BOFS;
                  default: nxt = S_OPR2;
               endcase
            end
            S_OPR2:    nxt = (mode_r == M_ABS) ? S_AHLD : S_IDX;
            S_AHLD:    nxt = S_RESTORE;
            S_ZIDX:    nxt = S_RESTORE;
            S_IDX:     nxt = co ? S_FIX : S_RESTORE;
            S_FIX:     nxt = S_RESTORE;
            S_BOFS:    nxt = taken ? S_BTGT : S_IDLE;
            S_BTGT:    nxt = (co ^ db7) ? S_BFIX : S_IDLE;
            S_BFIX:    nxt = S_IDLE;
            S_RESTORE: nxt = S_IDLE;
            S_VEC: begin
               if (vidx == VLAST) nxt = S_RESTORE;
               else               nvidx = vidx + 1'b1;
            end
            default:   nxt = S_IDLE;
         endcase
      end
   end

   // Control word is registered from the next state; dec_h takes db7 on the BTGT->BFIX step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         mode_r <= M_ZPX;
         vidx   <= '0;
         ctl    <= decode(S_IDLE, '0, 1'b0);
      end else if (rdy) begin
         state  <= nxt;
         mode_r <= nmode;
         vidx   <= nvidx;
         ctl    <= decode(nxt, nvidx, db7);
      end
   end

   assign op     = ctl.op;
   assign ci     = ctl.ci;
   assign cond   = ctl.cond;
   assign dec_h  = ctl.dec_h;
   assign busy   = ctl.busy;
   assign ld_ahl = ctl.ld_ahl & rdy;
   assign ld_pc  = ctl.ld_pc  & rdy;
   assign inc_pc = ctl.inc_pc & rdy;

   // Carry/branch-qualified done comes straight off the live path inputs.
   assign done = rdy & (ctl.done_u
                        | ((state == S_IDX)  & ~co)
                        | ((state == S_BOFS) & ~taken)
                        | ((state == S_BTGT) & ~(co ^ db7)));

endmodule

// File: tb/tb_abl_seq.sv
// Bench for abl_seq: directed cycle table, async reset case, and randomized
// transactions checked against a per-mode cycle-list model.
module tb_abl_seq;
   localparam int unsigned VEC_CNT = 2;

   logic       clk = 1'b0;
   logic       rst_n, start, taken, rdy, co, db7;
   logic [2:0] mode;
   logic [4:0] op;
   logic       ci, cond, ld_ahl, ld_pc, inc_pc, dec_h, busy, done;

   always #5 clk = ~clk;

   abl_seq #(.VEC_CNT(VEC_CNT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .taken(taken),
      .rdy(rdy), .co(co), .db7(db7), .op(op), .ci(ci), .cond(cond),
      .ld_ahl(ld_ahl), .ld_pc(ld_pc), .inc_pc(inc_pc), .dec_h(dec_h),
      .busy(busy), .done(done)
   );

   logic [12:0] act;
   assign act = {op, ci, cond, ld_ahl, ld_pc, inc_pc, dec_h, busy, done};

   int unsigned n_pass = 0;
   int unsigned n_chk  = 0;

   function automatic logic [12:0] o(input logic [4:0] op_e, input logic ci_e, input logic cond_e,
                                     input logic la, input logic lp, input logic ip,
                                     input logic dh, input logic bz, input logic dn);
      return {op_e, ci_e, cond_e, la, lp, ip, dh, bz, dn};
   endfunction

   task automatic check(input string nm, input logic [12:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b want %b (op,ci,cond,ld_ahl,ld_pc,inc_pc,dec_h,busy,done)",
                    nm, act, exp);
   endtask

   logic [12:0] IDL, P1, P2, IDX0, IDX1, FIX, RST, BOF0, BOF1, BTG0, BTG1, BFX0, BFX1;
   logic [12:0] ZID, ZIDS, V1, V2, AHL;

   typedef struct {
      logic        start;
      logic [2:0]  mode;
      logic        rdy, co, db7, taken;
      logic [12:0] exp;
      string       nm;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input logic s, input logic [2:0] m, input logic r, input logic c,
                      input logic d, input logic t, input logic [12:0] e, input string nm);
      vec_t v;
      v.start = s; v.mode = m; v.rdy = r; v.co = c; v.db7 = d; v.taken = t;
      v.exp = e; v.nm = nm;
      tbl.push_back(v);
   endtask

   // Reference model: each accepted request expands into its list of busy cycles.
   typedef struct {
      logic [12:0] exp;
      logic        co, db7, taken;
   } cyc_t;
   cyc_t q[$];

   task automatic push(input logic [12:0] e, input logic c, input logic d, input logic t);
      cyc_t x;
      x.exp = e; x.co = c; x.db7 = d; x.taken = t;
      q.push_back(x);
   endtask

   task automatic build(input logic [2:0] m, input logic tk, input logic co_i,
                        input logic co_b, input logic b7);
      q.delete();
      case (m)
         3'd0: begin push(P1, 0, 0, 0); push(ZID, 0, 0, 0); push(RST, 0, 0, 0); end
         3'd1: begin push(P1, 0, 0, 0); push(P2, 0, 0, 0); push(AHL, 0, 0, 0); push(RST, 0, 0, 0); end
         3'd2: begin
            push(P1, 0, 0, 0); push(P2, 0, 0, 0);
            push(o(5'b01001, 0, 0, 0, 0, 0, 0, 1, !co_i), co_i, 0, 0);
            if (co_i) push(FIX, 0, 0, 0);
            push(RST, 0, 0, 0);
         end
         3'd3: begin
            push(P1, 0, 0, 0);
            push(o(5'b00011, 1, 0, 0, 1, 1, 0, 1, !tk), 0, 0, tk);
            if (tk) begin
               push(o(5'b01111, 0, 1, 0, 1, 0, 0, 1, co_b == b7), co_b, b7, 0);
               if (co_b != b7) push(o(5'b10011, 0, 0, 0, 0, 0, b7, 1, 1), 0, 0, 0);
            end
         end
         3'd4: begin
            for (int k = 1; k <= int'(VEC_CNT); k++)
               push(o(5'b00000, 1'(k - 1), 0, k < int'(VEC_CNT), 0, 0, 0, 1, k == int'(VEC_CNT)), 0, 0, 0);
            push(RST, 0, 0, 0);
         end
         default: ;
      endcase
   endtask

   task automatic cyc(input logic s, input logic [2:0] m, input logic r, input logic c,
                      input logic d, input logic t);
      @(posedge clk); #1;
      start = s; mode = m; rdy = r; co = c; db7 = d; taken = t;
      @(negedge clk);
   endtask

   initial begin
      IDL  = o(5'b00011, 0, 0, 0, 0, 0, 0, 0, 0);
      P1   = o(5'b00011, 1, 0, 0, 1, 1, 0, 1, 0);
      P2   = o(5'b00011, 1, 0, 1, 1, 1, 0, 1, 0);
      IDX0 = o(5'b01001, 0, 0, 0, 0, 0, 0, 1, 1);
      IDX1 = o(5'b01001, 0, 0, 0, 0, 0, 0, 1, 0);
      FIX  = o(5'b10011, 0, 0, 0, 0, 0, 0, 1, 1);
      RST  = o(5'b00110, 0, 0, 0, 0, 0, 0, 1, 0);
      BOF0 = o(5'b00011, 1, 0, 0, 1, 1, 0, 1, 1);
      BOF1 = o(5'b00011, 1, 0, 0, 1, 1, 0, 1, 0);
      BTG0 = o(5'b01111, 0, 1, 0, 1, 0, 0, 1, 0);
      BTG1 = o(5'b01111, 0, 1, 0, 1, 0, 0, 1, 1);
      BFX0 = o(5'b10011, 0, 0, 0, 0, 0, 0, 1, 1);
      BFX1 = o(5'b10011, 0, 0, 0, 0, 0, 1, 1, 1);
      ZID  = o(5'b01101, 0, 1, 0, 0, 0, 0, 1, 1);
      ZIDS = o(5'b01101, 0, 1, 0, 0, 0, 0, 1, 0);
      V1   = o(5'b00000, 0, 0, 1, 0, 0, 0, 1, 0);
      V2   = o(5'b00000, 1, 0, 0, 0, 0, 0, 1, 1);
      AHL  = o(5'b01010, 0, 0, 0, 0, 0, 0, 1, 1);

      add(0, 0, 1, 0, 0, 0, IDL,  "idle");
      add(1, 2, 1, 0, 0, 0, IDL,  "absx_start");
      add(0, 0, 1, 0, 0, 0, P1,   "absx_opr1");
      add(0, 0, 1, 0, 0, 0, P2,   "absx_opr2");
      add(0, 0, 1, 0, 0, 0, IDX0, "absx_idx_nocross");
      add(0, 0, 1, 0, 0, 0, RST,  "absx_restore");
      add(0, 0, 1, 0, 0, 0, IDL,  "absx_idle");
      add(1, 2, 1, 0, 0, 0, IDL,  "absxc_start");
      add(0, 0, 1, 0, 0, 0, P1,   "absxc_opr1");
      add(0, 0, 1, 0, 0, 0, P2,   "absxc_opr2");
      add(0, 0, 1, 1, 0, 0, IDX1, "absxc_idx_cross");
      add(0, 0, 1, 0, 0, 0, FIX,  "absxc_fix");
      add(0, 0, 1, 0, 0, 0, RST,  "absxc_restore");
      add(0, 0, 1, 0, 0, 0, IDL,  "absxc_idle");
      add(1, 3, 1, 0, 0, 0, IDL,  "bback_start");
      add(0, 0, 1, 0, 0, 0, P1,   "bback_opr1");
      add(0, 0, 1, 0, 0, 1, BOF1, "bback_bofs");
      add(0, 0, 1, 0, 1, 0, BTG0, "bback_btgt");
      add(0, 0, 1, 0, 0, 0, BFX1, "bback_bfix");
      add(0, 0, 1, 0, 0, 0, IDL,  "bback_idle");
      add(1, 3, 1, 0, 0, 0, IDL,  "bnt_start");
      add(0, 0, 1, 0, 0, 0, P1,   "bnt_opr1");
      add(0, 0, 1, 0, 0, 0, BOF0, "bnt_bofs_done");
      add(0, 0, 1, 0, 0, 0, IDL,  "bnt_idle");
      add(1, 3, 1, 0, 0, 0, IDL,  "bfwd_start");
      add(0, 0, 1, 0, 0, 0, P1,   "bfwd_opr1");
      add(0, 0, 1, 0, 0, 1, BOF1, "bfwd_bofs");
      add(0, 0, 1, 0, 0, 0, BTG1, "bfwd_btgt_nofix");
      add(0, 0, 1, 0, 0, 0, IDL,  "bfwd_idle");
      add(1, 3, 1, 0, 0, 0, IDL,  "bfc_start");
      add(0, 0, 1, 0, 0, 0, P1,   "bfc_opr1");
      add(0, 0, 1, 0, 0, 1, BOF1, "bfc_bofs");
      add(0, 0, 1, 1, 0, 0, BTG0, "bfc_btgt");
      add(0, 0, 1, 0, 0, 0, BFX0, "bfc_bfix_inc");
      add(0, 0, 1, 0, 0, 0, IDL,  "bfc_idle");
      add(1, 0, 1, 0, 0, 0, IDL,  "zpx_start");
      add(0, 0, 1, 0, 0, 0, P1,   "zpx_opr1");
      add(0, 0, 0, 0, 0, 0, ZIDS, "zpx_stall1");
      add(1, 1, 0, 1, 0, 0, ZIDS, "zpx_stall2");
      add(0, 0, 0, 0, 1, 1, ZIDS, "zpx_stall3");
      add(0, 0, 1, 0, 0, 0, ZID,  "zpx_zidx_done");
      add(1, 1, 1, 0, 0, 0, RST,  "busy_start_ignored");
      add(0, 0, 1, 0, 0, 0, IDL,  "zpx_idle");
      add(1, 4, 1, 0, 0, 0, IDL,  "vec_start");
      add(0, 0, 1, 0, 0, 0, V1,   "vec1");
      add(1, 0, 1, 0, 0, 0, V2,   "vec2_done_start");
      add(0, 0, 1, 0, 0, 0, RST,  "vec_restore");
      add(0, 0, 1, 0, 0, 0, IDL,  "vec_idle");
      add(1, 6, 1, 0, 0, 0, IDL,  "rsvd_start");
      add(0, 0, 1, 0, 0, 0, IDL,  "rsvd_ignored");
      add(1, 1, 1, 0, 0, 0, IDL,  "abs_start");
      add(0, 0, 1, 0, 0, 0, P1,   "abs_opr1");
      add(0, 0, 1, 0, 0, 0, P2,   "abs_opr2");
      add(0, 0, 1, 0, 0, 0, AHL,  "abs_ahld");
      add(0, 0, 1, 0, 0, 0, RST,  "abs_restore");
      add(0, 0, 1, 0, 0, 0, IDL,  "abs_idle");

      rst_n = 1'b0; start = 1'b0; mode = 3'd0; rdy = 1'b1; co = 1'b0; db7 = 1'b0; taken = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_state", IDL);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset", IDL);

      foreach (tbl[i]) begin
         cyc(tbl[i].start, tbl[i].mode, tbl[i].rdy, tbl[i].co, tbl[i].db7, tbl[i].taken);
         check(tbl[i].nm, tbl[i].exp);
      end

      // Asynchronous reset while sitting in IDX of an ABSX request.
      cyc(1, 2, 1, 0, 0, 0); check("mrst_start", IDL);
      cyc(0, 0, 1, 0, 0, 0); check("mrst_opr1", P1);
      cyc(0, 0, 1, 0, 0, 0); check("mrst_opr2", P2);
      cyc(0, 0, 1, 1, 0, 0); check("mrst_idx", IDX1);
      #1 rst_n = 1'b0;
      #1 check("mrst_async", IDL);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mrst_after", IDL);
      cyc(0, 0, 1, 0, 0, 0); check("mrst_stay_idle", IDL);

      for (int t = 0; t < 300; t++) begin
         logic [2:0] m;
         logic       tk, ci_co, bt_co, b7;
         m     = 3'($urandom_range(0, 7));
         tk    = 1'($urandom);
         ci_co = 1'($urandom);
         bt_co = 1'($urandom);
         b7    = 1'($urandom);
         build(m, tk, ci_co, bt_co, b7);
         cyc(1, m, 1, 1'($urandom), 1'($urandom), 1'($urandom));
         check("rnd_start", IDL);
         foreach (q[j]) begin
            while ($urandom_range(0, 3) == 0) begin
               cyc(1'($urandom), 3'($urandom), 0, 1'($urandom), 1'($urandom), 1'($urandom));
               check("rnd_stall", q[j].exp & ~13'h039);
            end
            cyc(1'($urandom), 3'($urandom), 1, q[j].co, q[j].db7, q[j].taken);
            check("rnd_cycle", q[j].exp);
         end
         cyc(0, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         check("rnd_idle", IDL);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
